// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with a one-byte holding register and
// ready / overrun / framing-error status for the DataMemory MMIO window.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ovr_q, ovr_d;
  logic          fe_q, fe_d;

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    fe_d    = fe_q;

    // A CPU read clears status first so that a byte completing on the same
    // edge can re-assert rx_ready without raising overrun.
    if (rd_en) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      fe_d    = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            if (ready_q && !rd_en) ovr_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_ready  = ready_q;
  assign overrun   = ovr_q;
  assign frame_err = fe_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are driven on rx_in, expected
// bytes queued at drive time and popped when rx_ready rises.
module tb_uart_rx;

  localparam int CPB = 10;
  localparam int H   = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, overrun, frame_err, busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rd_en(rd_en),
    .rx_data(rx_data), .rx_ready(rx_ready), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit expect_it);
    if (expect_it) exp_q.push_back(b);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_in = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_ready(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (rx_ready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({rx_data, rx_ready, overrun, frame_err, busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: got data=%h rdy=%b ovr=%b fe=%b busy=%b, want all 0",
               rx_data, rx_ready, overrun, frame_err, busy);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    bit ok;
    logic [7:0] e;
    repeat (20) @(negedge clk);
    fork
      send_frame(8'h41, 0, 1'b1);
      wait_ready(150, n, ok);
    join
    tests++;
    if (!ok || n < 97 || n > 99) begin
      fails++;
      $display("FAIL single_latency: got ok=%0b cycles=%0d, want 97..99", ok, n);
    end
    e = exp_q.pop_front();
    tests++;
    if (rx_data !== e) begin
      fails++;
      $display("FAIL single_data: got %h want %h", rx_data, e);
    end
    tests++;
    if ({overrun, frame_err} !== 2'b00) begin
      fails++;
      $display("FAIL single_flags: got ovr=%b fe=%b want 0 0", overrun, frame_err);
    end
    pulse_rd();
    tests++;
    if (rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_rd_clear: got rdy=%b want 0", rx_ready);
    end
  endtask

  task automatic test_back_to_back();
    repeat (20) @(negedge clk);
    fork
      begin
        send_frame(8'h41, 0, 1'b1);
        send_frame(8'h42, 0, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int n;
          bit ok;
          logic [7:0] e;
          wait_ready(150, n, ok);
          tests++;
          if (!ok || exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b_rx%0d: got ok=%0b queued=%0d, want reception", k, ok, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            tests++;
            if ({rx_data, overrun, frame_err} !== {e, 2'b00}) begin
              fails++;
              $display("FAIL b2b_data%0d: got data=%h ovr=%b fe=%b want data=%h ovr=0 fe=0",
                       k, rx_data, overrun, frame_err, e);
            end
          end
          pulse_rd();
        end
      end
    join
  endtask

  task automatic test_overrun();
    repeat (20) @(negedge clk);
    fork
      begin
        send_frame(8'h55, 0, 1'b1);
        send_frame(8'hAA, 0, 1'b1);
      end
      begin
        int n;
        bit ok;
        logic [7:0] e;
        wait_ready(150, n, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || rx_data !== e) begin
          fails++;
          $display("FAIL ovr_first: got ok=%0b data=%h want data=%h", ok, rx_data, e);
        end
      end
    join
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tests++;
      if ({rx_data, rx_ready, overrun} !== {e, 2'b11}) begin
        fails++;
        $display("FAIL ovr_second: got data=%h rdy=%b ovr=%b want data=%h rdy=1 ovr=1",
                 rx_data, rx_ready, overrun, e);
      end
    end
    pulse_rd();
    tests++;
    if ({rx_ready, overrun} !== 2'b00) begin
      fails++;
      $display("FAIL ovr_clear: got rdy=%b ovr=%b want 0 0", rx_ready, overrun);
    end
  endtask

  task automatic test_framing();
    int n;
    bit ok;
    logic [7:0] e;
    repeat (20) @(negedge clk);
    fork
      send_frame(8'h33, 30, 1'b0);
      begin
        repeat (9 * CPB + 25) @(negedge clk);
        tests++;
        if ({busy, frame_err, rx_ready} !== 3'b110) begin
          fails++;
          $display("FAIL frame_hold: got busy=%b fe=%b rdy=%b want 1 1 0", busy, frame_err, rx_ready);
        end
      end
    join
    tests++;
    if ({busy, frame_err, rx_ready} !== 3'b010) begin
      fails++;
      $display("FAIL frame_release: got busy=%b fe=%b rdy=%b want 0 1 0", busy, frame_err, rx_ready);
    end
    repeat (10) @(negedge clk);
    fork
      send_frame(8'h34, 0, 1'b1);
      wait_ready(150, n, ok);
    join
    e = exp_q.pop_front();
    tests++;
    if (!ok || rx_data !== e) begin
      fails++;
      $display("FAIL frame_recover: got ok=%0b data=%h want %h", ok, rx_data, e);
    end
    pulse_rd();
    tests++;
    if ({rx_ready, frame_err} !== 2'b00) begin
      fails++;
      $display("FAIL frame_clear: got rdy=%b fe=%b want 0 0", rx_ready, frame_err);
    end
  endtask

  task automatic test_glitch();
    int n;
    repeat (20) @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy_set: got busy=%b want 1", busy);
    end
    n = 0;
    while (n < H + 3 && busy !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy_drop: got busy=%b after %0d cycles want 0", busy, n);
    end
    repeat (20) @(negedge clk);
    tests++;
    if ({rx_ready, overrun, frame_err} !== 3'b000) begin
      fails++;
      $display("FAIL glitch_norx: got rdy=%b ovr=%b fe=%b want 0 0 0", rx_ready, overrun, frame_err);
    end
  endtask

  task automatic test_simul_read();
    int n;
    bit ok;
    logic [7:0] e;
    repeat (20) @(negedge clk);
    fork
      send_frame(8'h99, 0, 1'b1);
      wait_ready(150, n, ok);
    join
    e = exp_q.pop_front();
    tests++;
    if (!ok || rx_data !== e) begin
      fails++;
      $display("FAIL simul_first: got ok=%0b data=%h want %h", ok, rx_data, e);
    end
    repeat (5) @(negedge clk);
    fork
      send_frame(8'h5A, 0, 1'b1);
      begin
        repeat (2 + H + 9 * CPB) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    e = exp_q.pop_front();
    tests++;
    if ({rx_data, rx_ready, overrun} !== {e, 2'b10}) begin
      fails++;
      $display("FAIL simul_read: got data=%h rdy=%b ovr=%b want data=%h rdy=1 ovr=0",
               rx_data, rx_ready, overrun, e);
    end
    pulse_rd();
  endtask

  task automatic test_reset_midframe();
    int n;
    bit ok;
    logic [7:0] e;
    repeat (20) @(negedge clk);
    fork
      send_frame(8'h77, 0, 1'b1);
      wait_ready(150, n, ok);
    join
    e = exp_q.pop_front();
    tests++;
    if (!ok || rx_data !== e) begin
      fails++;
      $display("FAIL rst_pre: got ok=%0b data=%h want %h", ok, rx_data, e);
    end
    repeat (5) @(negedge clk);
    fork
      send_frame(8'h0F, 0, 1'b0);
      begin
        repeat (5 * CPB + 3) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL rst_midframe_busy: got busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({rx_data, rx_ready, overrun, frame_err, busy} !== 12'h000) begin
          fails++;
          $display("FAIL rst_after: got data=%h rdy=%b ovr=%b fe=%b busy=%b want all 0",
                   rx_data, rx_ready, overrun, frame_err, busy);
        end
      end
    join
    repeat (200) @(negedge clk);
    pulse_rd();
    repeat (5) @(negedge clk);
    fork
      send_frame(8'hC3, 0, 1'b1);
      wait_ready(150, n, ok);
    join
    e = exp_q.pop_front();
    tests++;
    if (!ok || {rx_data, overrun, frame_err} !== {e, 2'b00}) begin
      fails++;
      $display("FAIL rst_next_frame: got ok=%0b data=%h ovr=%b fe=%b want data=%h ovr=0 fe=0",
               ok, rx_data, overrun, frame_err, e);
    end
    pulse_rd();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_simul_read();
    test_reset_midframe();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d bytes left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
